// File: rtl/pkt_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_parser_if
// Description : Byte-stream receive handshake plus parsed-header result bus
//               shared between a frame source (master) and pkt_parser (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_parser_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_ready;
  logic [2:0]  fPktType;
  logic [15:0] sourceID;
  logic [15:0] destinationID;
  logic [5:0]  payloadLen;
  logic        newpkt;
  logic        pkt_err;

  // Frame source / result consumer side
  modport master (
    output rx_byte, rx_valid, rx_sof, rx_eof,
    input  rx_ready, fPktType, sourceID, destinationID, payloadLen,
    input  newpkt, pkt_err
  );

  // Parser side
  modport slave (
    input  rx_byte, rx_valid, rx_sof, rx_eof,
    output rx_ready, fPktType, sourceID, destinationID, payloadLen,
    output newpkt, pkt_err
  );
endinterface
`default_nettype wire

// File: rtl/pkt_parser.sv
`default_nettype none
// ============================================================================
// Module      : pkt_parser
// Description : Parses byte-serial frames (5-byte header + payload) into
//               packet type, source/destination IDs and payload length.
//               Valid frames raise newpkt for one cycle, discarded frames
//               raise pkt_err for one cycle.
//               Optional feature macro PKT_CHECKSUM_EN: the last byte of each
//               frame is an XOR checksum over all preceding frame bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_parser #(
  parameter int MAX_LEN = 32,
  parameter int HDR_LEN = 5
) (
  input  logic         clk,
  input  logic         nrst,
  pkt_parser_if.slave  bus
);

  localparam int          CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [2:0]  IDX_LAST = 3'(HDR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DROP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q;
  logic [2:0]        idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [5:0]        pay_q;
  logic [2:0]        type_q;
  logic [15:0]       src_q;
  logic [15:0]       dst_q;
  logic              rx_ready_q;
  logic [2:0]        ptype_q;
  logic [15:0]       srcid_q;
  logic [15:0]       dstid_q;
  logic [5:0]        plen_q;
  logic              newpkt_q;
  logic              pkt_err_q;

  logic              accept;
  logic              cnt_full;
  logic              in_frame;

  assign accept   = bus.rx_valid & rx_ready_q;
  // Total frame bytes already at the limit: one more byte overflows.
  assign cnt_full = (cnt_q == CNT_W'(MAX_LEN));
  assign in_frame = (state_q == S_HDR) || (state_q == S_PAYLOAD);

`ifdef PKT_CHECKSUM_EN
  logic [7:0] cs_q;
  logic [7:0] cs_d;
  assign cs_d = cs_q ^ bus.rx_byte;
`endif

  // Frame FSM with registered handshake, pulses and published header fields
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pay_q      <= '0;
      type_q     <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rx_ready_q <= 1'b1;
      ptype_q    <= '0;
      srcid_q    <= '0;
      dstid_q    <= '0;
      plen_q     <= '0;
      newpkt_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      cs_q       <= '0;
`endif
    end else begin
      newpkt_q  <= 1'b0;
      pkt_err_q <= 1'b0;

      if (accept && bus.rx_sof && state_q != S_DONE) begin
        // A start byte always begins a new frame; an interrupted header or
        // payload is reported, a frame already dropped for overflow is not.
        // A start byte that is also an end byte cannot hold a header.
        if (in_frame || bus.rx_eof) pkt_err_q <= 1'b1;
        if (bus.rx_eof) begin
          state_q <= S_IDLE;
        end else begin
          type_q  <= bus.rx_byte[2:0];
          idx_q   <= 3'd1;
          cnt_q   <= CNT_W'(1);
          pay_q   <= '0;
          state_q <= S_HDR;
`ifdef PKT_CHECKSUM_EN
          cs_q    <= bus.rx_byte;
`endif
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            // Bytes outside a frame are accepted and dropped silently
          end

          S_HDR: begin
            if (accept) begin
              if (bus.rx_eof && idx_q != IDX_LAST) begin
                pkt_err_q <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                case (idx_q)
                  3'd1:    src_q[15:8] <= bus.rx_byte;
                  3'd2:    src_q[7:0]  <= bus.rx_byte;
                  3'd3:    dst_q[15:8] <= bus.rx_byte;
                  default: dst_q[7:0]  <= bus.rx_byte;
                endcase
                idx_q <= idx_q + 3'd1;
                cnt_q <= cnt_q + CNT_W'(1);
`ifdef PKT_CHECKSUM_EN
                cs_q  <= cs_d;
`endif
                if (idx_q == IDX_LAST) begin
                  if (bus.rx_eof) begin
`ifdef PKT_CHECKSUM_EN
                    // Header-only frame has no room for a checksum byte
                    pkt_err_q <= 1'b1;
                    state_q   <= S_IDLE;
`else
                    ptype_q    <= type_q;
                    srcid_q    <= src_q;
                    dstid_q    <= {dst_q[15:8], bus.rx_byte};
                    plen_q     <= '0;
                    newpkt_q   <= 1'b1;
                    rx_ready_q <= 1'b0;
                    state_q    <= S_DONE;
`endif
                  end else begin
                    state_q <= S_PAYLOAD;
                  end
                end
              end
            end
          end

          S_PAYLOAD: begin
            if (accept) begin
              if (cnt_full) begin
                pkt_err_q <= 1'b1;
                state_q   <= bus.rx_eof ? S_IDLE : S_DROP;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                pay_q <= pay_q + 6'd1;
`ifdef PKT_CHECKSUM_EN
                cs_q  <= cs_d;
`endif
                if (bus.rx_eof) begin
`ifdef PKT_CHECKSUM_EN
                  // Checksum byte itself is not payload
                  if (cs_q == bus.rx_byte) begin
                    ptype_q    <= type_q;
                    srcid_q    <= src_q;
                    dstid_q    <= dst_q;
                    plen_q     <= pay_q;
                    newpkt_q   <= 1'b1;
                    rx_ready_q <= 1'b0;
                    state_q    <= S_DONE;
                  end else begin
                    pkt_err_q <= 1'b1;
                    state_q   <= S_IDLE;
                  end
`else
                  ptype_q    <= type_q;
                  srcid_q    <= src_q;
                  dstid_q    <= dst_q;
                  plen_q     <= pay_q + 6'd1;
                  newpkt_q   <= 1'b1;
                  rx_ready_q <= 1'b0;
                  state_q    <= S_DONE;
`endif
                end
              end
            end
          end

          S_DROP: begin
            if (accept && bus.rx_eof) state_q <= S_IDLE;
          end

          S_DONE: begin
            // One stall cycle while the published fields are presented
            rx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end

          default: begin
            rx_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.fPktType      = ptype_q;
  assign bus.sourceID      = srcid_q;
  assign bus.destinationID = dstid_q;
  assign bus.payloadLen    = plen_q;
  assign bus.newpkt        = newpkt_q;
  assign bus.pkt_err       = pkt_err_q;

endmodule
`default_nettype wire

// File: doc/pkt_parser.md
PKT_PARSER -- requirements
Module: pkt_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32: maximum accepted frame length in bytes, header included.
REQ-002 SHALL have parameter HDR_LEN, fixed at 5: header bytes per frame.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx_byte, input, 8 bits: received frame byte.
REQ-006 SHALL have port rx_valid, input, 1 bit: rx_byte valid; a byte is accepted when rx_valid and rx_ready are both high.
REQ-007 SHALL have port rx_sof, input, 1 bit: qualifies the accepted byte as the first of a frame.
REQ-008 SHALL have port rx_eof, input, 1 bit: qualifies the accepted byte as the last of a frame.
REQ-009 SHALL have port rx_ready, output, 1 bit: parser can accept a byte.
REQ-010 SHALL have port fPktType, output, 3 bits: packet type, byte0[2:0].
REQ-011 SHALL have port sourceID, output, 16 bits: bytes 1 (MSB) and 2 (LSB).
REQ-012 SHALL have port destinationID, output, 16 bits: bytes 3 (MSB) and 4 (LSB).
REQ-013 SHALL have port payloadLen, output, 6 bits: number of payload bytes after the header, checksum byte excluded.
REQ-014 SHALL have port newpkt, output, 1 bit: one-cycle pulse marking a valid frame; consumed by the packet filter.
REQ-015 SHALL have port pkt_err, output, 1 bit: one-cycle pulse marking a discarded frame.

Function
REQ-016 SHALL implement states IDLE, HDR, PAYLOAD, DROP and DONE.
REQ-017 In IDLE, an accepted byte with rx_sof SHALL capture byte0, set the byte index to 1 and go to HDR; accepted bytes without rx_sof SHALL be ignored.
REQ-018 In HDR, bytes at indices 1-4 SHALL be captured into shadow registers.
REQ-019 After index 4 is accepted, the FSM SHALL go to PAYLOAD, or to DONE if rx_eof is high on that byte.
REQ-020 An rx_eof at index 0-3 SHALL abort the frame: pkt_err pulses, FSM returns to IDLE.
REQ-021 In PAYLOAD, each accepted byte SHALL increment the payload counter; rx_eof on the accepted byte SHALL go to DONE.
REQ-022 When the total byte count would exceed MAX_LEN, the FSM SHALL pulse pkt_err once and go to DROP.
REQ-023 DROP SHALL discard bytes until an accepted rx_eof, then return to IDLE.
REQ-024 An rx_sof accepted in HDR, PAYLOAD or DROP SHALL pulse pkt_err for the aborted frame and restart parsing with that byte as byte0; DROP entry from overflow SHALL NOT pulse pkt_err a second time.
REQ-025 In DONE, the shadow registers SHALL be copied to fPktType, sourceID, destinationID and payloadLen, newpkt SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-026 newpkt SHALL rise in the cycle after the rx_eof byte is accepted (latency 1).
REQ-027 The outputs fPktType, sourceID, destinationID and payloadLen SHALL change only in DONE and hold their values until the next DONE.
REQ-028 rx_ready SHALL be 0 in DONE and 1 in all other states; back-to-back frames therefore need one gap cycle.
REQ-029 byte0[7:3] SHALL be ignored.
REQ-030 newpkt and pkt_err SHALL never be high in the same cycle.

Reset
REQ-031 While nrst is low: FSM is in IDLE, counters and shadow registers are 0, all outputs are 0 except rx_ready, which is 1.
REQ-032 Reset mid-frame SHALL discard the frame with no newpkt and no pkt_err.

Configuration
REQ-033 Macro PKT_CHECKSUM_EN: when defined, the rx_eof byte of each frame SHALL be an XOR checksum of all preceding frame bytes.
REQ-034 With PKT_CHECKSUM_EN defined, a frame shorter than 6 bytes or with a checksum mismatch SHALL pulse pkt_err instead of newpkt, and the outputs SHALL stay unchanged.
REQ-035 With PKT_CHECKSUM_EN defined, payloadLen SHALL exclude the checksum byte.
REQ-036 Without PKT_CHECKSUM_EN, no checksum is checked and every byte after the header counts as payload.

Verification
REQ-037 Frame 05,00,12,00,34,AA,BB (eof on BB), no checksum -> newpkt 1 cycle after BB; fPktType=5, sourceID=0x0012, destinationID=0x0034, payloadLen=2.
REQ-038 5-byte frame 03,00,01,00,02 with eof on byte4 -> newpkt; payloadLen=0; rx_ready low during the DONE cycle.
REQ-039 3-byte frame with eof on byte2 -> pkt_err pulse, no newpkt, outputs keep their prior values.
REQ-040 With MAX_LEN=32, a 40-byte frame -> single pkt_err at byte 33; a following valid frame parses correctly.
REQ-041 rx_sof at index 3, then a valid frame -> pkt_err once, followed by newpkt carrying the new frame's fields.
REQ-042 PKT_CHECKSUM_EN, frame 01,00,01,00,02,CS with CS=02 -> newpkt; same frame with CS=FF -> pkt_err; nrst low mid-frame -> neither pulse.
